// File: rtl/fib_pkg.sv
// Shared types and default sizes for the second-order recurrence engine.
package fib_pkg;

    localparam int FIB_WIDTH = 32;
    localparam int FIB_NW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } fib_state_e;

endpackage

// File: rtl/fib_step.sv
// One recurrence step: WIDTH-bit sum of the two held terms plus carry-out.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             a_ovf_i,
    input  logic             b_ovf_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

    // Wrap inherited from either operand; the caller adds this step's own carry.
    assign ovf_o = a_ovf_i | b_ovf_i;

endmodule

// File: rtl/fib_seq_engine.sv
// Programmable-seed recurrence engine with start/busy/done control and a
// valid/ready streaming mode that emits t0..tn.
module fib_seq_engine
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int NW    = FIB_NW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NW-1:0]    n,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             stream_mode,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data,
    output logic [NW-1:0]    out_index,
    output logic             out_valid,
    output logic             overflow
);

    // Handshake: a beat transfers on a rising clk edge where out_valid and
    // out_ready are both high; while out_ready is low every output holds.

    fib_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [NW-1:0]    k_q;
    logic [NW-1:0]    n_q;
    logic             a_ovf_q;
    logic             b_ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;

    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             inh_ovf_d;
    logic             a_ovf_d;
    logic             last_d;
    logic             step_d;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a_i     (a_q),
        .b_i     (b_q),
        .a_ovf_i (a_ovf_q),
        .b_ovf_i (b_ovf_q),
        .sum_o   (sum_d),
        .carry_o (carry_d),
        .ovf_o   (inh_ovf_d)
    );

    assign a_ovf_d = inh_ovf_d | carry_d;
    assign last_d  = (k_q == n_q);
    assign step_d  = (state_q == ST_RUN) || ((state_q == ST_STREAM) && out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        b_q     <= seed0;
                        a_q     <= seed1;
                        k_q     <= '0;
                        n_q     <= n;
                        a_ovf_q <= 1'b0;
                        b_ovf_q <= 1'b0;
                        busy_q  <= 1'b1;
                        valid_q <= stream_mode;
                        state_q <= stream_mode ? ST_STREAM : ST_RUN;
                    end
                end
                ST_RUN, ST_STREAM: begin
                    if (step_d) begin
                        // k is compared before incrementing, so n = 2^NW-1 never wraps k.
                        if (last_d) begin
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            b_q     <= a_q;
                            b_ovf_q <= a_ovf_q;
                            a_q     <= sum_d;
                            a_ovf_q <= a_ovf_d;
                            k_q     <= k_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_data  = b_q;
    assign out_index = k_q;
    assign overflow  = b_ovf_q;

endmodule
